// File: rtl/shake_pkg.sv
// Shared SHAKE256 definitions: lane geometry, domain suffix and control FSM states.
// Macro ABSORB_SHA3_PAD_EN selects the SHA3 domain suffix instead of the SHAKE one.
package shake_pkg;

    localparam int unsigned RATE_BITS  = 1088;
    localparam int unsigned STATE_BITS = 1600;
    localparam int unsigned LANE_W     = 64;
    localparam int unsigned RATE_LANES = RATE_BITS / LANE_W;

`ifdef ABSORB_SHA3_PAD_EN
    localparam logic [7:0] SUFFIX = 8'h06;
`else
    localparam logic [7:0] SUFFIX = 8'h1F;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_PAD,
        ST_XOR,
        ST_START,
        ST_WAIT,
        ST_DONE
    } absorb_state_e;

endpackage

// File: rtl/absorb_mod_pad_lane.sv
// Pads one message lane: keeps the first n bytes, places the domain suffix at byte n,
// and sets the lane MSB when the lane is the top lane of the rate block.
module pad_lane #(
    parameter int unsigned LANE_W = shake_pkg::LANE_W
) (
    input  logic [LANE_W-1:0] data,
    input  logic [3:0]        n,
    input  logic              top,
    output logic [LANE_W-1:0] padded_c
);
    import shake_pkg::*;

    localparam int unsigned NB = LANE_W / 8;

    always_comb begin
        padded_c = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (4'(i) < n) begin
                padded_c[8*i +: 8] = data[8*i +: 8];
            end else if (4'(i) == n) begin
                padded_c[8*i +: 8] = SUFFIX;
            end
        end
        padded_c[LANE_W-1] = padded_c[LANE_W-1] | top;
    end

endmodule

// File: rtl/absorb_mod.sv
// SHAKE256 absorb front end: collects rate blocks of message lanes, pads the final
// block, XORs it into the state and drives the permutation handshake.
module absorb_mod #(
    parameter int unsigned RATE        = shake_pkg::RATE_BITS,
    parameter int unsigned STATE_WIDTH = shake_pkg::STATE_BITS,
    parameter int unsigned LANE_W      = shake_pkg::LANE_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   absorb_start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANE_W-1:0]      in_data,
    input  logic                   in_last,
    input  logic [3:0]             in_bytes,
    output logic                   perm_start,
    input  logic                   perm_done,
    input  logic [STATE_WIDTH-1:0] perm_state,
    output logic [STATE_WIDTH-1:0] state_out,
    output logic                   absorb_done
);
    import shake_pkg::*;

    localparam int unsigned LANES = RATE / LANE_W;
    localparam int unsigned CW    = $clog2(LANES + 1);
    localparam int unsigned NB    = LANE_W / 8;
    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

    absorb_state_e          state_q, state_d;
    logic [STATE_WIDTH-1:0] st_q;
    logic [RATE-1:0]        buf_q, pad_blk;
    logic [CW-1:0]          cnt_q, c_q, c_nx;
    logic [3:0]             n_q, n_in;
    logic                   final_q, pend_q, accept;
    logic [LANE_W-1:0]      lane_c, padded_c;

    assign accept    = in_valid && (state_q == ST_COLLECT);
    assign n_in      = (in_bytes > 4'(NB)) ? 4'(NB) : in_bytes;
    assign lane_c    = buf_q[c_q*LANE_W +: LANE_W];
    assign c_nx      = (c_q == LAST_LANE) ? c_q : c_q + CW'(1);
    assign state_out = st_q;

    pad_lane #(.LANE_W(LANE_W)) u_pad_lane (
        .data     (lane_c),
        .n        (n_q),
        .top      (c_q == LAST_LANE),
        .padded_c (padded_c)
    );

    // Padded block; a full final lane pushes the suffix into the next lane,
    // or, when it is the top lane, leaves this block unpadded and owes an extra one.
    always_comb begin
        pad_blk = buf_q;
        if (n_q < 4'(NB)) begin
            pad_blk[c_q*LANE_W +: LANE_W] = padded_c;
            pad_blk[RATE-1]               = 1'b1;
        end else if (c_q != LAST_LANE) begin
            pad_blk[c_nx*LANE_W +: LANE_W] = LANE_W'(SUFFIX);
            pad_blk[RATE-1]                = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (absorb_start) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (accept) begin
                    if (in_last)                 state_d = ST_PAD;
                    else if (cnt_q == LAST_LANE) state_d = ST_XOR;
                end
            end
            ST_PAD:   state_d = ST_XOR;
            ST_XOR:   state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (perm_done) begin
                    if (!final_q)    state_d = ST_COLLECT;
                    else if (pend_q) state_d = ST_PAD;
                    else             state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q        <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
            c_q         <= '0;
            n_q         <= '0;
            final_q     <= 1'b0;
            pend_q      <= 1'b0;
            in_ready    <= 1'b0;
            perm_start  <= 1'b0;
            absorb_done <= 1'b0;
        end else begin
            in_ready    <= (state_d == ST_COLLECT);
            perm_start  <= (state_d == ST_START);
            absorb_done <= (state_q == ST_WAIT) && (state_d == ST_DONE);
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (absorb_start) begin
                        st_q    <= '0;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        final_q <= 1'b0;
                        pend_q  <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        buf_q[cnt_q*LANE_W +: LANE_W] <= in_data;
                        cnt_q <= cnt_q + CW'(1);
                        if (in_last) begin
                            final_q <= 1'b1;
                            c_q     <= cnt_q;
                            n_q     <= n_in;
                        end
                    end
                end
                ST_PAD: begin
                    buf_q <= pad_blk;
                    if (n_q == 4'(NB) && c_q == LAST_LANE) pend_q <= 1'b1;
                end
                ST_XOR: begin
                    st_q[RATE-1:0] <= st_q[RATE-1:0] ^ buf_q;
                end
                ST_WAIT: begin
                    if (perm_done) begin
                        st_q  <= perm_state;
                        buf_q <= '0;
                        cnt_q <= '0;
                        if (pend_q) begin
                            pend_q <= 1'b0;
                            c_q    <= '0;
                            n_q    <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_absorb_mod.sv
// Self-checking bench for absorb_mod against a byte-level SHAKE padding model.
module tb_absorb_mod;

    localparam int RB = 136;
`ifdef ABSORB_SHA3_PAD_EN
    localparam logic [7:0] SUF = 8'h06;
`else
    localparam logic [7:0] SUF = 8'h1F;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          absorb_start;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic          perm_start;
    logic          perm_done;
    logic [1599:0] perm_state;
    logic [1599:0] state_out;
    logic          absorb_done;

    int nerr = 0;
    int nchk = 0;
    int pulses = 0;
    logic [1599:0] msta;
    logic [1599:0] first_snap;
    byte unsigned msg[$];
    byte unsigned pad[$];

    absorb_mod dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .absorb_start (absorb_start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_bytes     (in_bytes),
        .perm_start   (perm_start),
        .perm_done    (perm_done),
        .perm_state   (perm_state),
        .state_out    (state_out),
        .absorb_done  (absorb_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (perm_start === 1'b1) pulses++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
        int d;
        d = 0;
        for (int i = 24; i >= 0; i--) if (obs[64*i +: 64] !== exp[64*i +: 64]) d = i;
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s lane%0d got %h want %h", tag, d, obs[64*d +: 64], exp[64*d +: 64]);
        end
    endtask

    task automatic fill_rand(input int len);
        msg.delete();
        repeat (len) msg.push_back(8'($urandom));
    endtask

    task automatic perm_phase(input int b, input int lat, input bit fin, input int hold);
        int w;
        logic bad;
        logic [1599:0] ps;
        w = 0;
        while (perm_start !== 1'b1 && w < 10) begin
            tick;
            w++;
        end
        chk("perm_start_seen", perm_start, 1);
        chk("perm_latency", w, lat);
        for (int j = 0; j < RB; j++) msta[8*j +: 8] = msta[8*j +: 8] ^ pad[RB*b + j];
        if (b == 0) first_snap = state_out;
        chk("state_xor", state_out, msta);
        chk("ready_low_perm", in_ready, 0);
        tick;
        chk("start_one_cycle", perm_start, 0);
        bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (in_ready !== 1'b0 || perm_start !== 1'b0 || absorb_done !== 1'b0) bad = 1'b1;
            tick;
        end
        chk("hold_quiet", bad, 0);
        for (int k = 0; k < 50; k++) ps[32*k +: 32] = $urandom;
        perm_state = ps;
        perm_done  = 1'b1;
        tick;
        perm_done  = 1'b0;
        msta = ps;
        chk("perm_load", state_out, msta);
        chk("absorb_done", absorb_done, fin);
        if (fin) begin
            tick;
            chk("done_one_cycle", absorb_done, 0);
        end
    endtask

    task automatic run_msg(input int hold, input bit big, input bit noise);
        int len, nb, nl, nlast, b, w, p0, idx;
        bit rdy, last;
        logic [63:0] lane;
        len = msg.size();
        pad.delete();
        foreach (msg[i]) pad.push_back(msg[i]);
        pad.push_back(SUF);
        while (pad.size() % RB != 0) pad.push_back(8'h00);
        pad[pad.size()-1] = pad[pad.size()-1] | 8'h80;
        nb    = pad.size() / RB;
        nl    = (len == 0) ? 1 : (len + 7) / 8;
        nlast = len - 8 * (nl - 1);
        p0    = pulses;

        absorb_start = 1'b1;
        tick;
        absorb_start = 1'b0;
        msta = '0;
        chk("start_clears", state_out, msta);
        chk("ready_collect", in_ready, 1);
        if (noise) begin
            perm_state = {50{32'hDEADBEEF}};
            perm_done  = 1'b1;
            tick;
            perm_done  = 1'b0;
            chk("stray_done", state_out, msta);
        end

        b = 0;
        for (int i = 0; i < nl; i++) begin
            if ($urandom % 4 == 0) begin
                in_valid = 1'b0;
                tick;
            end
            for (int j = 0; j < 8; j++) begin
                idx = 8 * i + j;
                lane[8*j +: 8] = (idx < len) ? msg[idx] : 8'($urandom);
            end
            last     = (i == nl - 1);
            in_data  = lane;
            in_last  = last;
            in_bytes = last ? 4'(nlast) : 4'($urandom);
            if (last && big && nlast == 8) in_bytes = 4'($urandom_range(9, 15));
            if (noise && i == 0) absorb_start = 1'b1;
            in_valid = 1'b1;
            w = 0;
            do begin
                rdy = in_ready;
                tick;
                w++;
            end while (!rdy && w < 50);
            absorb_start = 1'b0;
            in_valid     = 1'b0;
            in_last      = 1'b0;
            if (!rdy) chk("lane_accept_timeout", 0, 1);
            if (!last && (i % 17) == 16) begin
                perm_phase(b, 1, 1'b0, hold);
                b++;
            end
        end
        while (b < nb) begin
            perm_phase(b, 2, b == nb - 1, hold);
            b++;
        end
        chk("perm_pulse_count", pulses - p0, nb);
    endtask

    initial begin
        int w;
        reset_n      = 1'b0;
        absorb_start = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        in_bytes     = '0;
        perm_done    = 1'b0;
        perm_state   = '0;
        repeat (3) tick;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_perm_start", perm_start, 0);
        chk("rst_absorb_done", absorb_done, 0);
        chk("rst_state_out", state_out, 0);
        reset_n = 1'b1;
        tick;
        chk("idle_not_ready", in_ready, 0);

        // Empty message
        msg.delete();
        run_msg(0, 1'b0, 1'b0);
        chk("empty_byte0", first_snap[7:0], SUF);
        chk("empty_top_bit", first_snap[1087], 1);

        // "abc"
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        run_msg(2, 1'b0, 1'b0);
        chk("abc_lane0", first_snap[63:0], {32'h0, SUF, 24'h636261});
        chk("abc_capacity", first_snap[1599:1088], 0);

        // 17 full lanes ending with in_bytes=8: extra pad block
        fill_rand(136);
        run_msg(1, 1'b0, 1'b0);

        // Final lane 16 with 7 bytes: suffix shares the top byte
        fill_rand(135);
        run_msg(0, 1'b0, 1'b0);
        chk("top_byte", first_snap[1087:1080], SUF | 8'h80);

        // Long permutation hold-off
        fill_rand(60);
        run_msg(20, 1'b0, 1'b0);

        // Oversized in_bytes and ignored control pulses
        fill_rand(16);
        run_msg(0, 1'b1, 1'b1);

        repeat (12) begin
            fill_rand($urandom_range(0, 420));
            run_msg($urandom_range(0, 4), 1'($urandom % 2), 1'($urandom % 2));
        end

        // Reset while waiting on the permutation
        absorb_start = 1'b1;
        tick;
        absorb_start = 1'b0;
        in_data  = 64'h0123456789ABCDEF;
        in_last  = 1'b1;
        in_bytes = 4'd5;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        in_last  = 1'b0;
        w = 0;
        while (perm_start !== 1'b1 && w < 10) begin
            tick;
            w++;
        end
        chk("rst_test_perm_start", perm_start, 1);
        tick;
        tick;
        #2 reset_n = 1'b0;
        #1;
        chk("async_in_ready", in_ready, 0);
        chk("async_perm_start", perm_start, 0);
        chk("async_absorb_done", absorb_done, 0);
        chk("async_state_out", state_out, 0);
        tick;
        reset_n = 1'b1;
        tick;
        chk("post_rst_idle", in_ready, 0);
        fill_rand(20);
        run_msg(1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/absorb_mod.md
# absorb_mod

Absorb front end of the SHAKE256 core, the inbound counterpart of the squeeze stage. Accepts a message as a stream of 64-bit lanes, collects one rate block (17 lanes for RATE=1088), applies SHAKE multi-rate padding, XORs the block into the rate portion of the 1600-bit state, and hands the state to the Keccak-f permutation with a start/done handshake. After the final padded block is permuted, it pulses `absorb_done`; the squeeze stage can then read `state_out`.

## Interface
- `RATE`, 1088, rate in bits; must be a multiple of `LANE_W`
- `STATE_WIDTH`, 1600, Keccak state width
- `LANE_W`, 64, input lane width
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `absorb_start` in 1: one-cycle pulse that clears the state and begins a new message
- `in_valid` in 1: input lane valid
- `in_ready` out 1: block accepts a lane this cycle
- `in_data` in LANE_W: message lane, little-endian; byte 0 = bits [7:0]
- `in_last` in 1: final lane of the message
- `in_bytes` in 4: valid bytes in the final lane, 0..8; ignored unless `in_last`; values >8 treated as 8
- `perm_start` out 1: one-cycle pulse; `state_out` is valid for the permutation
- `perm_done` in 1: permutation finished; `perm_state` is valid
- `perm_state` in STATE_WIDTH: permuted state
- `state_out` out STATE_WIDTH: current state register
- `absorb_done` out 1: one-cycle pulse after the final block is permuted

## Operation
- States: IDLE, COLLECT, PAD, XOR, START, WAIT, DONE.
- IDLE/DONE: `absorb_start` → clear state, buffer and lane counter; go to COLLECT. `absorb_start` is ignored in all other states.
- COLLECT: `in_ready`=1. On each handshake (`in_valid`&&`in_ready`), lane `cnt` of the buffer ← `in_data` and `cnt`++.
  - Non-last lane at `cnt`=LANES-1 → XOR (full block, not final).
  - Last lane → PAD, with final flag set.
- PAD: applied to the final lane index `c` with `n`=`in_bytes`.
  - Bytes ≥`n` of lane `c` are zeroed, and byte `n` ← suffix 0x1F.
  - Bit RATE-1 is then ORed with 1 (0x80 into the top byte of the block). When `c`=LANES-1 and `n`=7, the top byte is 0x9F.
  - If `n`=8, the suffix goes into lane `c`+1, byte 0.
  - If `n`=8 and `c`=LANES-1, the full block is absorbed unpadded, then an extra block is built and absorbed: lane 0 = 0x1F, bit RATE-1 = 1, all else 0.
- XOR: `state[RATE-1:0]` ^= buffer; capacity bits are unchanged. Go to START.
- START: `perm_start`=1 for one cycle. Go to WAIT.
- WAIT: on `perm_done`, state ← `perm_state`, buffer and `cnt` cleared.
  - Go to COLLECT if not final.
  - Go to the pending pad block if one is owed.
  - Otherwise go to DONE and pulse `absorb_done`.
- `perm_done` outside WAIT is ignored.
- Empty message: first lane has `in_last`=1 and `in_bytes`=0 → block = 0x1F at byte 0 plus bit RATE-1.

## Timing
- Reset values: `in_ready`=0, `perm_start`=0, `absorb_done`=0, `state_out`=0; FSM in IDLE.
- Full non-final block: last lane accepted at edge k → XOR at edge k+1 → `perm_start` high during cycle k+1..k+2.
- Final lane accepted at edge k → PAD k+1 → XOR k+2 → `perm_start` during cycle after k+2.
- `perm_done` sampled at edge m → `absorb_done` high for the single cycle after m, when the block is final.
- `in_ready` is low outside COLLECT. No input is lost while the block is not ready.
- `reset_n` low at any time, including mid-block or in WAIT, asynchronously returns every output to its reset value.
- Throughput: one lane per cycle in COLLECT.

## Configuration
- `ABSORB_SHA3_PAD_EN` defined: domain suffix is 0x06 (SHA3 mode).
- Not defined: suffix is 0x1F (SHAKE). All other behaviour is identical.

## Structure
- Shared package `shake_pkg` holds:
  - `LANE_W`, `RATE_LANES`=RATE/LANE_W, and the `SUFFIX` constant (selected by the macro)
  - the FSM state enum, shared with the squeeze control
- One sub-module: `pad_lane`, combinational. Given lane data, `n`, and a top-lane flag, it returns the padded lane.

## Test plan
- Empty message (`in_last`, `in_bytes`=0) → block XORed: byte0=0x1F, bit 1087=1; one `perm_start`; `absorb_done` after `perm_done`.
- 3-byte message 0x636261 → lane0 = 0x1F636261, bit 1087=1; capacity bits of `state_out` unchanged before permutation.
- 17 full lanes, last on lane 16 with `in_bytes`=8 → two `perm_start` pulses; second block = 0x1F at lane0 plus bit 1087.
- Final lane 16 with `in_bytes`=7 → top byte = 0x9F; exactly one permutation.
- `perm_done` held off 20 cycles → `in_ready`=0 throughout; after `perm_done`, `state_out` == `perm_state`.
- `reset_n` asserted in WAIT → all outputs 0 immediately; `absorb_start` then restarts cleanly.
